mp_load_unit: RTL
=================

// Module: mp_load_unit
// PURPOSE
//  Consumer side of the MP pipeline latch. Takes the latched memory-stage bundle, issues word
//  reads to the data cache (two reads when the access spills across a word) and merges the bytes.
//  Returns a right-justified, zero-extended load value to the next stage.
//  Drives the stall that freezes the MP latch until the load completes.
// PARAMETERS
//  ADDR_W  15  physical byte-address width; must match the MP latch phys_addr field
// PORTS
//  clk           in   1       clock; all state updates on the rising edge
//  rst           in   1       asynchronous, active-low reset
//  i_v           in   1       MP latch valid
//  i_mem_rd      in   1       instruction performs a memory read (control-store bit)
//  i_phys_addr   in   ADDR_W  byte address of the load
//  i_reqSize     in   2       00=1B, 01=2B, 10=4B, 11=reserved (treated as 4B)
//  i_spill       in   1       access crosses a 4-byte word; used as given, never recomputed
//  i_flush       in   1       pipeline flush; aborts the in-flight load
//  i_stall_down  in   1       next stage cannot accept a result
//  o_req_v       out  1       cache read request valid
//  o_req_addr    out  ADDR_W  word-aligned request address, bits [1:0] always 0
//  i_req_ack     in   1       cache accepts the request this cycle
//  i_rsp_v       in   1       cache read data valid; never in the same cycle as its ack
//  i_rsp_data    in   32      little-endian aligned word
//  o_data        out  32      merged load result
//  o_data_v      out  1       o_data valid
//  o_stall_up    out  1       hold the MP latch (drives the latch's stall input)
// BEHAVIOUR
//  Reset (rst=0): async entry to IDLE; o_req_v=0, o_req_addr=0, o_data=0, o_data_v=0,
//   drop flag=0; o_stall_up forced to 0 while rst=0.
//  States and transitions:
//   IDLE  -> REQ1 when i_v & i_mem_rd & !i_flush; captures addr, size and spill.
//         i_v & !i_mem_rd: no stall, no request.
//   REQ1  o_req_v=1, addr={a[ADDR_W-1:2],00}; on i_req_ack -> WAIT1.
//   WAIT1 on i_rsp_v: word0<=data; -> REQ2 if spill, else DONE.
//   REQ2  o_req_v=1, addr=word addr+4, modulo 2^ADDR_W (0x7FFC+4 wraps to 0x0000);
//         on i_req_ack -> WAIT2.
//   WAIT2 on i_rsp_v: word1<=data; -> DONE.
//   DONE  o_data_v=1; -> IDLE when !i_stall_down.
//  Merge: o_data = ({word1,word0} >> 8*a[1:0]), masked to 8/16/32 bits by size; upper bits zero.
//   Registered on entry to DONE; stable for the whole of DONE.
//  o_stall_up (combinational) = (IDLE & i_v & i_mem_rd) | REQ1 | WAIT1 | REQ2 | WAIT2
//   | (DONE & i_stall_down). In DONE with !i_stall_down it is 0, so the latch advances in that
//   same cycle.
//  Latency: best case for a non-spill load with ack in REQ1 and rsp one cycle later is
//   IDLE, REQ1, WAIT1, DONE = 4 cycles. A spill adds 2 cycles.
//  Only one request outstanding; o_req_v and o_req_addr hold steady until acked.
//  i_flush in any state -> IDLE next cycle; o_data_v=0 and o_req_v dropped.
//   If flushed in WAIT1/WAIT2, or in REQ1/REQ2 with i_req_ack=1, set drop.
//   While drop=1, the next i_rsp_v is discarded and clears drop. No new request issues until
//   drop clears; o_stall_up stays 1 if a new load is presented.
//  Flush in DONE: result discarded.
//  i_rsp_v outside WAIT1/WAIT2 with drop=0 is ignored.
//  Reset mid-operation abandons everything; a stale response after reset is ignored.
// TESTING
//  1 Aligned load: a=0x0010, size 10, rsp 0xDDCCBBAA -> o_data=0xDDCCBBAA, one request,
//    o_data_v for 1 cycle.
//  2 Spill: a=0x0013, size 01, spill=1; words 0x44332211@0x10, 0x88776655@0x14
//    -> requests 0x0010 then 0x0014, o_data=0x00005544.
//  3 Wrap: a=0x7FFE, size 10, spill=1 -> second request addr 0x0000;
//    o_data={rsp2[15:0],rsp1[31:16]}.
//  4 Back-pressure: i_stall_down=1 for 3 cycles in DONE -> o_data and o_data_v stable,
//    o_stall_up=1; both release when i_stall_down drops.
//  5 Flush in WAIT1, then a new load at 0x0020; late rsp 0xDEADBEEF
//    -> stale rsp dropped, new load returns its own data, no 0xDEADBEEF in o_data.
//  6 Byte load a=0x0021, size 00, rsp 0x11223344 -> o_data=0x00000033.
//    Reset asserted in WAIT2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mp_load_unit.sv
// mp_load_unit: consumer side of the MP latch; issues one or two word reads
// to the data cache per load and returns a right-justified, zero-extended value.
module mp_load_unit #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_v,
    input  logic              i_mem_rd,
    input  logic [ADDR_W-1:0] i_phys_addr,
    input  logic [1:0]        i_reqSize,
    input  logic              i_spill,
    input  logic              i_flush,
    input  logic              i_stall_down,
    output logic              o_req_v,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_req_ack,
    input  logic              i_rsp_v,
    input  logic [31:0]       i_rsp_data,
    output logic [31:0]       o_data,
    output logic              o_data_v,
    output logic              o_stall_up
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_e;

    state_e            state_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              spill_q;
    logic [31:0]       word0_q;
    logic              drop_q;
    logic              req_v_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       data_q;
    logic              data_v_q;
    logic              flush_drop;

    function automatic logic [31:0] merge(input logic [63:0] w,
                                          input logic [1:0]  off,
                                          input logic [1:0]  sz);
        logic [31:0] sh;
        sh = 32'(w >> {off, 3'b000});
        case (sz)
            2'b00:   merge = {24'h0, sh[7:0]};
            2'b01:   merge = {16'h0, sh[15:0]};
            default: merge = sh;
        endcase
    endfunction

    // A flush after the cache has taken the request leaves a response in flight.
    assign flush_drop = (state_q == WAIT1) || (state_q == WAIT2) ||
                        (((state_q == REQ1) || (state_q == REQ2)) && i_req_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            spill_q    <= 1'b0;
            word0_q    <= 32'h0;
            drop_q     <= 1'b0;
            req_v_q    <= 1'b0;
            req_addr_q <= '0;
            data_q     <= 32'h0;
            data_v_q   <= 1'b0;
        end else begin
            if (drop_q && i_rsp_v)
                drop_q <= 1'b0;
            if (i_flush) begin
                state_q  <= IDLE;
                req_v_q  <= 1'b0;
                data_v_q <= 1'b0;
                if (flush_drop)
                    drop_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_v && i_mem_rd && !drop_q) begin
                            off_q      <= i_phys_addr[1:0];
                            size_q     <= i_reqSize;
                            spill_q    <= i_spill;
                            req_v_q    <= 1'b1;
                            req_addr_q <= {i_phys_addr[ADDR_W-1:2], 2'b00};
                            state_q    <= REQ1;
                        end
                    end
                    REQ1: begin
                        if (i_req_ack) begin
                            req_v_q <= 1'b0;
                            state_q <= WAIT1;
                        end
                    end
                    WAIT1: begin
                        if (i_rsp_v) begin
                            word0_q <= i_rsp_data;
                            if (spill_q) begin
                                req_v_q    <= 1'b1;
                                req_addr_q <= req_addr_q + ADDR_W'(4);
                                state_q    <= REQ2;
                            end else begin
                                data_q   <= merge({32'h0, i_rsp_data}, off_q, size_q);
                                data_v_q <= 1'b1;
                                state_q  <= DONE;
                            end
                        end
                    end
                    REQ2: begin
                        if (i_req_ack) begin
                            req_v_q <= 1'b0;
                            state_q <= WAIT2;
                        end
                    end
                    WAIT2: begin
                        if (i_rsp_v) begin
                            data_q   <= merge({i_rsp_data, word0_q}, off_q, size_q);
                            data_v_q <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    DONE: begin
                        if (!i_stall_down) begin
                            data_v_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_stall_up = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE:    o_stall_up = i_v & i_mem_rd;
                DONE:    o_stall_up = i_stall_down;
                default: o_stall_up = 1'b1;
            endcase
        end
    end

    assign o_req_v    = req_v_q;
    assign o_req_addr = req_addr_q;
    assign o_data     = data_q;
    assign o_data_v   = data_v_q;

endmodule
